ahb_sram_ctrl_ws: RTL and testbench

Parametrised AHB-Lite slave to asynchronous SRAM bridge, next generation of the single-width zero-wait controller. Adds configurable data/address width, programmable wait-state count with HREADYOUT stretching, SEQ transfer support and a bus-turnaround cycle on read-to-write. Sits between the AHB interconnect and the external SRAM pins; one instance per SRAM device.

---
 rtl/ahb_sram_pkg.sv | 26 ++
 rtl/ahb_sram_ctrl_ws_if.sv | 25 ++
 rtl/ahb_sram_wait_cnt.sv | 26 ++
 rtl/ahb_sram_ctrl_ws.sv | 116 +++++++++++
 tb/tb_ahb_sram_ctrl_ws.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared encodings for the AHB-Lite to asynchronous SRAM bridge:
// HTRANS values, controller states and the wait counter width.
package ahb_sram_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    TURN
  } state_e;

  // BUSY and IDLE both request no access.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_ws_if.sv
// AHB-Lite slave-side signal bundle for the SRAM bridge.
interface ahb_sram_ctrl_ws_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 21
);

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;

  modport slave (
    input  HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );

  modport master (
    output HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

endinterface

// File: rtl/ahb_sram_wait_cnt.sv
// Loadable down counter that counts remaining wait cycles of an SRAM
// data phase; holds at zero until reloaded.
module ahb_sram_wait_cnt
  import ahb_sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ahb_sram_ctrl_ws.sv
// AHB-Lite slave to asynchronous SRAM bridge with programmable wait states,
// SEQ support and a turnaround cycle between a read and a following write.
module ahb_sram_ctrl_ws
  import ahb_sram_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               HCLK,
  input  logic               reset,
  ahb_sram_ctrl_ws_if.slave  bus,
  output logic [ADDR_W-1:0]  A,
  inout  wire  [DATA_W-1:0]  DQ,
  output logic               CE_b,
  output logic               WE_b,
  output logic               OE_b
);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             ready;
  logic             accept;

  ahb_sram_wait_cnt u_wait_cnt (
    .clk      (HCLK),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      A     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        A <= bus.HADDR;
      end
    end
  end

  // Strobes and ready are decoded straight from state/counter.
  always_comb begin
    ready = 1'b1;
    CE_b  = 1'b1;
    WE_b  = 1'b1;
    OE_b  = 1'b1;
    case (state)
      WRITE: begin
        CE_b  = 1'b0;
        WE_b  = 1'b0;
        ready = cnt_zero;
      end
      READ: begin
        CE_b  = 1'b0;
        OE_b  = 1'b0;
        ready = cnt_zero;
      end
      TURN:    ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  assign accept = bus.HREADY && ready && is_active(bus.HTRANS);

  // The final data-phase cycle doubles as the next address phase, so a
  // new accept there chains straight into the next data phase.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = bus.HWRITE ? WRITE : READ;
          cnt_load = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_zero) begin
          if (accept) begin
            state_nx = bus.HWRITE ? WRITE : READ;
            cnt_load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      READ: begin
        if (cnt_zero) begin
          if (accept) begin
            state_nx = bus.HWRITE ? TURN : READ;
            cnt_load = !bus.HWRITE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      TURN: begin
        state_nx = WRITE;
        cnt_load = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign DQ            = (state == WRITE) ? bus.HWDATA : 'z;
  assign bus.HRDATA    = (state == READ && cnt_zero) ? DQ : '0;
  assign bus.HREADYOUT = ready;

endmodule

// File: tb/tb_ahb_sram_ctrl_ws.sv
// Bench for ahb_sram_ctrl_ws: four instances (WAIT_CYCLES 0..3) share the
// AHB stimulus, each with its own SRAM model and HREADY looped from HREADYOUT.
module tb_ahb_sram_ctrl_ws;

  localparam int unsigned NI = 4;

  logic        HCLK = 1'b0;
  logic        reset;
  logic [20:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [7:0]  hwdata;

  logic        hro_a [NI];
  logic        ce_a  [NI];
  logic        we_a  [NI];
  logic        oe_a  [NI];
  logic [7:0]  hrd_a [NI];
  logic [20:0] a_a   [NI];
  logic [7:0]  dq_a  [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahb_sram_ctrl_ws_if #(.DATA_W(8), .ADDR_W(21)) bus ();
    logic [20:0] a;
    logic        ce_b, we_b, oe_b;
    wire  [7:0]  dq;
    logic [7:0]  mem [256];

    assign bus.HADDR  = haddr;
    assign bus.HTRANS = htrans;
    assign bus.HWRITE = hwrite;
    assign bus.HWDATA = hwdata;
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_ctrl_ws #(.DATA_W(8), .ADDR_W(21), .WAIT_CYCLES(g)) dut (
      .HCLK  (HCLK),
      .reset (reset),
      .bus   (bus),
      .A     (a),
      .DQ    (dq),
      .CE_b  (ce_b),
      .WE_b  (we_b),
      .OE_b  (oe_b)
    );

    assign dq = (!ce_b && !oe_b) ? mem[a[7:0]] : 'z;

    always @(posedge HCLK) begin
      if (reset) begin
        for (int i = 0; i < 256; i++)
          mem[i] <= (i == 255) ? 8'h3C : (i == 64) ? 8'hC3 : 8'h00;
      end else if (!ce_b && !we_b) begin
        mem[a[7:0]] <= dq;
      end
    end

    assign hro_a[g] = bus.HREADYOUT;
    assign ce_a[g]  = ce_b;
    assign we_a[g]  = we_b;
    assign oe_a[g]  = oe_b;
    assign hrd_a[g] = bus.HRDATA;
    assign a_a[g]   = a;
    assign dq_a[g]  = dq;
  end

  typedef struct {
    logic [1:0]  t;
    logic        w;
    logic [20:0] ad;
    logic [7:0]  d;
    logic        hro, ce, we, oe;
    logic [7:0]  hrd;
    logic [20:0] a;
    int          dqm;   // 0: skip, 1: DQ must carry HWDATA, 2: DQ must not
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic [1:0] t, input logic w, input logic [20:0] ad,
                              input logic [7:0] d, input logic hro, input logic ce,
                              input logic we, input logic oe, input logic [7:0] hrd,
                              input logic [20:0] a, input int dqm);
    vec_t v;
    v.t = t; v.w = w; v.ad = ad; v.d = d;
    v.hro = hro; v.ce = ce; v.we = we; v.oe = oe;
    v.hrd = hrd; v.a = a; v.dqm = dqm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic hro, input logic ce,
                         input logic we, input logic oe, input logic [7:0] hrd,
                         input logic [20:0] a);
    chk({tag, ".hreadyout"}, 32'(hro_a[k]), 32'(hro));
    chk({tag, ".ce_b"},      32'(ce_a[k]),  32'(ce));
    chk({tag, ".we_b"},      32'(we_a[k]),  32'(we));
    chk({tag, ".oe_b"},      32'(oe_a[k]),  32'(oe));
    chk({tag, ".hrdata"},    32'(hrd_a[k]), 32'(hrd));
    chk({tag, ".a"},         32'(a_a[k]),   32'(a));
  endtask

  task automatic chk_drv(input string tag, input int k);
    chk({tag, ".dq"}, 32'(dq_a[k]), 32'(hwdata));
  endtask

  task automatic chk_nodrv(input string tag, input int k);
    n_chk++;
    if (dq_a[k] === hwdata) begin
      n_fail++;
      $display("FAIL %s.dq_released: got %h, must not carry HWDATA %h", tag, dq_a[k], hwdata);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [20:0] ad,
                       input logic [7:0] d);
    @(posedge HCLK);
    #1;
    htrans = t; hwrite = w; haddr = ad; hwdata = d;
    @(negedge HCLK);
  endtask

  task automatic do_reset(input int n);
    htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
    reset  = 1'b1;
    repeat (n) @(posedge HCLK);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);
    hwdata = 8'h5A;
    @(negedge HCLK);
    for (int k = 0; k < NI; k++) begin
      chk_all($sformatf("reset%0d", k), k, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h0);
      chk_nodrv($sformatf("reset%0d", k), k);
    end

    // WAIT_CYCLES=0 instance, one row per clock cycle.
    tbl[0]  = mk(2'b10, 1'b1, 21'h10, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h00, 2);
    tbl[1]  = mk(2'b10, 1'b0, 21'h10, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h10, 1);
    tbl[2]  = mk(2'b00, 1'b0, 21'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 21'h10, 0);
    tbl[3]  = mk(2'b10, 1'b1, 21'h20, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h10, 2);
    tbl[4]  = mk(2'b10, 1'b1, 21'h21, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h20, 1);
    tbl[5]  = mk(2'b10, 1'b0, 21'h20, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h21, 1);
    tbl[6]  = mk(2'b10, 1'b1, 21'h22, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 21'h20, 0);
    tbl[7]  = mk(2'b00, 1'b0, 21'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 21'h22, 2);
    tbl[8]  = mk(2'b00, 1'b0, 21'h00, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h22, 1);
    tbl[9]  = mk(2'b01, 1'b0, 21'h30, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h22, 2);
    tbl[10] = mk(2'b10, 1'b0, 21'h22, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h22, 2);
    tbl[11] = mk(2'b00, 1'b0, 21'h00, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 21'h22, 0);
    tbl[12] = mk(2'b00, 1'b0, 21'h00, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h22, 2);

    do_reset(2);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].t, tbl[i].w, tbl[i].ad, tbl[i].d);
      chk_all($sformatf("w0row%0d", i), 0, tbl[i].hro, tbl[i].ce, tbl[i].we, tbl[i].oe,
              tbl[i].hrd, tbl[i].a);
      if (tbl[i].dqm == 1) chk_drv($sformatf("w0row%0d", i), 0);
      if (tbl[i].dqm == 2) chk_nodrv($sformatf("w0row%0d", i), 0);
    end

    // WAIT_CYCLES=2: read at top address, two stretched cycles then data.
    do_reset(2);
    drive(2'b10, 1'b0, 21'h1FFFFF, 8'h00);
    drive(2'b00, 1'b0, 21'h0, 8'h00);
    chk_all("w2rd_c1", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h1FFFFF);
    drive(2'b00, 1'b0, 21'h0, 8'h00);
    chk_all("w2rd_c2", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h1FFFFF);
    drive(2'b00, 1'b0, 21'h0, 8'h00);
    chk_all("w2rd_c3", 2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 21'h1FFFFF);
    drive(2'b00, 1'b0, 21'h0, 8'h00);
    chk_all("w2rd_idle", 2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h1FFFFF);

    // WAIT_CYCLES=1: NONSEQ read then SEQ write through the TURN cycle.
    do_reset(2);
    drive(2'b10, 1'b0, 21'h40, 8'h00);
    drive(2'b11, 1'b1, 21'h41, 8'h00);
    chk_all("turn_rd1", 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h40);
    drive(2'b11, 1'b1, 21'h41, 8'h00);
    chk_all("turn_rd2", 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 21'h40);
    drive(2'b00, 1'b0, 21'h0, 8'h9E);
    chk_all("turn_tc", 1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 21'h41);
    chk_nodrv("turn_tc", 1);
    drive(2'b00, 1'b0, 21'h0, 8'h9E);
    chk_all("turn_wr1", 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 21'h41);
    chk_drv("turn_wr1", 1);
    drive(2'b00, 1'b0, 21'h0, 8'h9E);
    chk_all("turn_wr2", 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h41);
    chk_drv("turn_wr2", 1);
    drive(2'b00, 1'b0, 21'h0, 8'h9E);
    chk_all("turn_idle", 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h41);

    // WAIT_CYCLES=1: BUSY offered at a transfer boundary is not an access.
    do_reset(2);
    drive(2'b10, 1'b1, 21'h50, 8'h00);
    drive(2'b01, 1'b0, 21'h0, 8'h12);
    chk_all("busy_wr1", 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 21'h50);
    chk_drv("busy_wr1", 1);
    drive(2'b01, 1'b0, 21'h0, 8'h12);
    chk_all("busy_wr2", 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h50);
    drive(2'b11, 1'b1, 21'h51, 8'h12);
    chk_all("busy_gap", 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h50);
    chk_nodrv("busy_gap", 1);
    drive(2'b00, 1'b0, 21'h0, 8'h34);
    chk_all("busy_seq1", 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 21'h51);
    chk_drv("busy_seq1", 1);
    drive(2'b00, 1'b0, 21'h0, 8'h34);
    chk_all("busy_seq2", 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 21'h51);
    drive(2'b00, 1'b0, 21'h0, 8'h34);
    chk_all("busy_idle", 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h51);

    // WAIT_CYCLES=3: reset in the middle of the write wait.
    do_reset(2);
    drive(2'b10, 1'b1, 21'h60, 8'h00);
    drive(2'b00, 1'b0, 21'h0, 8'h44);
    chk_all("rst_wr1", 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 21'h60);
    chk_drv("rst_wr1", 3);
    drive(2'b00, 1'b0, 21'h0, 8'h44);
    chk_all("rst_wr2", 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 21'h60);
    @(posedge HCLK);
    #1;
    reset = 1'b1;
    #1;
    chk_all("rst_mid", 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h0);
    chk_nodrv("rst_mid", 3);
    @(posedge HCLK);
    #1;
    reset = 1'b0;
    @(negedge HCLK);
    chk_all("rst_rel", 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h0);
    chk_nodrv("rst_rel", 3);
    drive(2'b00, 1'b0, 21'h0, 8'h44);
    chk_all("rst_idle", 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 21'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
